pio_target: RTL and testbench

PIO_TARGET -- requirements
Module: pio_target

---
 rtl/sap1_pio_pkg.sv | 32 +++
 rtl/pio_intr.sv | 54 +++++
 rtl/pio_target.sv | 160 ++++++++++++++++
 tb/tb_pio_target.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sap1_pio_pkg.sv
// Shared constants for the SAP1 PIO target: register map, bit positions,
// fixed read values and the command FSM state type.
package sap1_pio_pkg;

    localparam logic [15:0] ADDR_ID        = 16'h0000;
    localparam logic [15:0] ADDR_CTRL      = 16'h0004;
    localparam logic [15:0] ADDR_STATUS    = 16'h0008;
    localparam logic [15:0] ADDR_SCRATCH   = 16'h000C;
    localparam logic [15:0] ADDR_INT_STAT  = 16'h0010;
    localparam logic [15:0] ADDR_INT_EN    = 16'h0014;
    localparam logic [15:0] ADDR_ERR_ADDR  = 16'h0018;
    localparam logic [15:0] ADDR_CYCLE_CNT = 16'h001C;

    localparam logic [31:0] ID_VALUE      = 32'h5A50_0001;
    localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

    localparam int CTRL_RUN_BIT  = 0;
    localparam int CTRL_STEP_BIT = 1;
    localparam int STAT_HALT_BIT = 0;
    localparam int STAT_RUN_BIT  = 1;
    localparam int INT_HALT_BIT  = 0;
    localparam int INT_UNMAP_BIT = 1;
    localparam int INT_OVR_BIT   = 2;
    localparam int INT_W         = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/pio_intr.sv
// Interrupt block: halt rising-edge detect, W1C INT_STAT, INT_EN and the
// registered irq output. Hardware set wins over a same-cycle W1C clear.
module pio_intr
    import sap1_pio_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              halt_i,
    input  logic              set_unmap_i,
    input  logic              set_ovr_i,
    input  logic              clr_wr_i,
    input  logic              en_wr_i,
    input  logic [INT_W-1:0]  wdata_i,
    output logic [INT_W-1:0]  int_stat_o,
    output logic [INT_W-1:0]  int_en_o,
    output logic              irq_o
);
    logic              halt_q, halt_prev_q, halt_rise;
    logic [INT_W-1:0]  stat_q, stat_d, en_q, en_d, set_vec, clr_vec;
    logic              irq_q;

    assign halt_rise = halt_q & ~halt_prev_q;

    always_comb begin
        set_vec                = '0;
        set_vec[INT_HALT_BIT]  = halt_rise;
        set_vec[INT_UNMAP_BIT] = set_unmap_i;
        set_vec[INT_OVR_BIT]   = set_ovr_i;
        clr_vec                = clr_wr_i ? wdata_i : '0;
        stat_d                 = (stat_q & ~clr_vec) | set_vec;
        en_d                   = en_wr_i ? wdata_i : en_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            halt_q      <= 1'b0;
            halt_prev_q <= 1'b0;
            stat_q      <= '0;
            en_q        <= '0;
            irq_q       <= 1'b0;
        end else begin
            halt_q      <= halt_i;
            halt_prev_q <= halt_q;
            stat_q      <= stat_d;
            en_q        <= en_d;
            irq_q       <= |(stat_q & en_q);
        end
    end

    assign int_stat_o = stat_q;
    assign int_en_o   = en_q;
    assign irq_o      = irq_q;

endmodule

// File: rtl/pio_target.sv
// SAP1 PIO register target: three-state command FSM, register decode and
// core control. Optional CYCLE_CNT register enabled by SAP1_PIO_CYCLE_CNT_EN.
module pio_target
    import sap1_pio_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pio_cmd_vld,
    input  logic [15:0] pio_addr,
    input  logic        pio_rw,
    input  logic [31:0] pio_data_w,
    output logic        pio_rd_vld,
    output logic [31:0] pio_data_r,
    input  logic        halt_i,
    output logic        run_o,
    output logic        step_o,
    output logic        irq_o
);
    state_e        state_q, state_d;
    logic [15:0]   cmd_addr_q;
    logic          cmd_rw_q;
    logic [31:0]   cmd_wdata_q;
    logic [15:0]   word_addr;
    logic          in_acc, is_mapped, wr_hit;
    logic [31:0]   rdata;
    logic          run_q, run_d, step_q, step_d, rd_vld_q, rd_vld_d;
    logic [31:0]   data_r_q, data_r_d, scratch_q, scratch_d;
    logic [15:0]   err_addr_q, err_addr_d;
    logic [INT_W-1:0] int_stat, int_en;

    assign word_addr = {cmd_addr_q[15:2], 2'b00};
    assign in_acc    = (state_q == ST_ACC);
    assign wr_hit    = in_acc & ~cmd_rw_q & is_mapped;

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = pio_cmd_vld ? ST_ACC : ST_IDLE;
            ST_ACC:  state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Command fields are captured only when a command is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && pio_cmd_vld) begin
            cmd_addr_q  <= pio_addr;
            cmd_rw_q    <= pio_rw;
            cmd_wdata_q <= pio_data_w;
        end
    end

`ifdef SAP1_PIO_CYCLE_CNT_EN
    logic [31:0] cyc_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n)
            cyc_cnt_q <= '0;
        else if (wr_hit && word_addr == ADDR_CYCLE_CNT)
            cyc_cnt_q <= '0;
        else if (run_q)
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
    end
`endif

    always_comb begin
        rdata     = '0;
        is_mapped = 1'b1;
        case (word_addr)
            ADDR_ID:       rdata = ID_VALUE;
            ADDR_CTRL:     rdata[CTRL_RUN_BIT] = run_q;
            ADDR_STATUS: begin
                rdata[STAT_HALT_BIT] = halt_i;
                rdata[STAT_RUN_BIT]  = run_q;
            end
            ADDR_SCRATCH:  rdata = scratch_q;
            ADDR_INT_STAT: rdata[INT_W-1:0] = int_stat;
            ADDR_INT_EN:   rdata[INT_W-1:0] = int_en;
            ADDR_ERR_ADDR: rdata[15:0] = err_addr_q;
`ifdef SAP1_PIO_CYCLE_CNT_EN
            ADDR_CYCLE_CNT: rdata = cyc_cnt_q;
`endif
            default: begin
                is_mapped = 1'b0;
                rdata     = UNMAPPED_DATA;
            end
        endcase
    end

    // The read response is registered out of ACC so it appears during RESP.
    always_comb begin
        run_d      = run_q;
        step_d     = 1'b0;
        scratch_d  = scratch_q;
        err_addr_d = err_addr_q;
        rd_vld_d   = 1'b0;
        data_r_d   = '0;
        if (in_acc) begin
            if (cmd_rw_q) begin
                rd_vld_d = 1'b1;
                data_r_d = rdata;
            end
            if (!is_mapped) err_addr_d = cmd_addr_q;
        end
        if (wr_hit) begin
            case (word_addr)
                ADDR_CTRL: begin
                    run_d  = cmd_wdata_q[CTRL_RUN_BIT];
                    step_d = cmd_wdata_q[CTRL_STEP_BIT];
                end
                ADDR_SCRATCH: scratch_d = cmd_wdata_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_q      <= 1'b0;
            step_q     <= 1'b0;
            scratch_q  <= '0;
            err_addr_q <= '0;
            rd_vld_q   <= 1'b0;
            data_r_q   <= '0;
        end else begin
            run_q      <= run_d;
            step_q     <= step_d;
            scratch_q  <= scratch_d;
            err_addr_q <= err_addr_d;
            rd_vld_q   <= rd_vld_d;
            data_r_q   <= data_r_d;
        end
    end

    pio_intr u_intr (
        .clk         (clk),
        .reset_n     (reset_n),
        .halt_i      (halt_i),
        .set_unmap_i (in_acc & ~is_mapped),
        .set_ovr_i   ((state_q != ST_IDLE) & pio_cmd_vld),
        .clr_wr_i    (wr_hit && word_addr == ADDR_INT_STAT),
        .en_wr_i     (wr_hit && word_addr == ADDR_INT_EN),
        .wdata_i     (cmd_wdata_q[INT_W-1:0]),
        .int_stat_o  (int_stat),
        .int_en_o    (int_en),
        .irq_o       (irq_o)
    );

    assign pio_rd_vld = rd_vld_q;
    assign pio_data_r = data_r_q;
    assign run_o      = run_q;
    assign step_o     = step_q;

endmodule

// File: tb/tb_pio_target.sv
// Directed + randomized bench for pio_target against a register-level model.
module tb_pio_target;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pio_cmd_vld;
    logic [15:0] pio_addr;
    logic        pio_rw;
    logic [31:0] pio_data_w;
    logic        pio_rd_vld;
    logic [31:0] pio_data_r;
    logic        halt_i;
    logic        run_o;
    logic        step_o;
    logic        irq_o;

    int errors = 0;
    int checks = 0;

    logic        m_run;
    logic        m_halt;
    logic [31:0] m_scratch;
    logic [2:0]  m_stat;
    logic [2:0]  m_en;
    logic [15:0] m_err;
    logic [31:0] m_cyc;

    always #5 clk = ~clk;

    pio_target dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pio_cmd_vld(pio_cmd_vld),
        .pio_addr   (pio_addr),
        .pio_rw     (pio_rw),
        .pio_data_w (pio_data_w),
        .pio_rd_vld (pio_rd_vld),
        .pio_data_r (pio_data_r),
        .halt_i     (halt_i),
        .run_o      (run_o),
        .step_o     (step_o),
        .irq_o      (irq_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_mapped(input logic [15:0] a);
        logic [15:0] w;
        w = {a[15:2], 2'b00};
`ifdef SAP1_PIO_CYCLE_CNT_EN
        return w <= 16'h001C;
`else
        return w <= 16'h0018;
`endif
    endfunction

    function automatic logic [31:0] m_read(input logic [15:0] a);
        logic [15:0] w;
        w = {a[15:2], 2'b00};
        if (!m_mapped(a))   return 32'hDEAD_BEEF;
        if (w == 16'h0000)  return 32'h5A50_0001;
        if (w == 16'h0004)  return {31'd0, m_run};
        if (w == 16'h0008)  return {30'd0, m_run, m_halt};
        if (w == 16'h000C)  return m_scratch;
        if (w == 16'h0010)  return {29'd0, m_stat};
        if (w == 16'h0014)  return {29'd0, m_en};
        if (w == 16'h0018)  return {16'd0, m_err};
        return m_cyc;
    endfunction

    task automatic m_reset();
        m_run = 1'b0; m_scratch = '0; m_stat = '0; m_en = '0; m_err = '0; m_cyc = '0;
    endtask

    // One full command: drive, check ACC/RESP/IDLE cycle by cycle, update model.
    task automatic xact(input logic rw, input logic [15:0] a, input logic [31:0] d);
        logic [31:0] exp_rd;
        logic        exp_step;
        logic [15:0] w;
        w        = {a[15:2], 2'b00};
        exp_rd   = m_read(a);
        exp_step = !rw && w == 16'h0004 && d[1];
        pio_cmd_vld = 1'b1; pio_rw = rw; pio_addr = a; pio_data_w = d;
        @(posedge clk); #1;
        pio_cmd_vld = 1'b0;
        chk("acc_rd_vld", {31'd0, pio_rd_vld}, 32'd0);
        chk("acc_data_r", pio_data_r, 32'd0);
        @(posedge clk); #1;
        chk("resp_rd_vld", {31'd0, pio_rd_vld}, {31'd0, rw});
        chk("resp_data_r", pio_data_r, rw ? exp_rd : 32'd0);
        chk("resp_step", {31'd0, step_o}, {31'd0, exp_step});
        if (!m_mapped(a)) begin
            m_stat[1] = 1'b1;
            m_err     = a;
        end else if (!rw) begin
            if (w == 16'h0004) m_run = d[0];
            if (w == 16'h000C) m_scratch = d;
            if (w == 16'h0010) m_stat = m_stat & ~d[2:0];
            if (w == 16'h0014) m_en = d[2:0];
            if (w == 16'h001C) m_cyc = '0;
        end
        @(posedge clk); #1;
        chk("idle_rd_vld", {31'd0, pio_rd_vld}, 32'd0);
        chk("idle_step", {31'd0, step_o}, 32'd0);
        chk("run_o", {31'd0, run_o}, {31'd0, m_run});
        chk("irq_o", {31'd0, irq_o}, {31'd0, |(m_stat & m_en)});
    endtask

    initial begin
        logic [15:0] ra;
        logic        rrw;
        logic [31:0] rd;

        reset_n = 1'b0; pio_cmd_vld = 1'b0; pio_addr = '0; pio_rw = 1'b0;
        pio_data_w = '0; halt_i = 1'b0; m_halt = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_vld", {31'd0, pio_rd_vld}, 32'd0);
        chk("rst_data_r", pio_data_r, 32'd0);
        chk("rst_run", {31'd0, run_o}, 32'd0);
        chk("rst_step", {31'd0, step_o}, 32'd0);
        chk("rst_irq", {31'd0, irq_o}, 32'd0);

        // Command presented in the very first cycle after reset release.
        reset_n = 1'b1;
        xact(1'b1, 16'h0000, 32'd0);

        xact(1'b0, 16'h000C, 32'h1234_5678);
        xact(1'b1, 16'h000C, 32'd0);
        xact(1'b0, 16'h0004, 32'h0000_0002);
        xact(1'b1, 16'h0004, 32'd0);

        xact(1'b1, 16'h0040, 32'd0);
        xact(1'b1, 16'h0010, 32'd0);
        xact(1'b1, 16'h0018, 32'd0);
        xact(1'b0, 16'h0014, 32'h0000_0002);
        chk("irq_unmap_en", {31'd0, irq_o}, 32'd1);
        xact(1'b0, 16'h0010, 32'h0000_0002);
        chk("irq_after_w1c", {31'd0, irq_o}, 32'd0);

        // Back-to-back strobes: the second lands in ACC and is dropped.
        pio_cmd_vld = 1'b1; pio_rw = 1'b1; pio_addr = 16'h000C;
        @(posedge clk); #1;
        @(posedge clk); #1;
        pio_cmd_vld = 1'b0;
        chk("ovr_resp_vld", {31'd0, pio_rd_vld}, 32'd1);
        chk("ovr_resp_data", pio_data_r, m_scratch);
        m_stat[2] = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("ovr_no_2nd_resp", {31'd0, pio_rd_vld}, 32'd0);
        end
        xact(1'b1, 16'h0010, 32'd0);
        xact(1'b0, 16'h0010, 32'h0000_0007);
        xact(1'b1, 16'h0010, 32'd0);

        // Halt rise lands on the same edge as the W1C of bit 0.
        halt_i = 1'b1; m_halt = 1'b1;
        xact(1'b0, 16'h0010, 32'h0000_0001);
        m_stat[0] = 1'b1;
        xact(1'b1, 16'h0010, 32'd0);
        xact(1'b1, 16'h0008, 32'd0);
        halt_i = 1'b0; m_halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset asserted while a read sits in ACC.
        pio_cmd_vld = 1'b1; pio_rw = 1'b1; pio_addr = 16'h0000;
        @(posedge clk); #1;
        pio_cmd_vld = 1'b0; reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_reset();
        repeat (3) begin
            chk("rst_mid_no_resp", {31'd0, pio_rd_vld}, 32'd0);
            @(posedge clk); #1;
        end
        xact(1'b1, 16'h000C, 32'd0);
        xact(1'b1, 16'h0010, 32'd0);
        xact(1'b1, 16'h0018, 32'd0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0)
                ra = 16'($urandom_range(16'h0020, 16'hFFFF));
            else
                ra = 16'(($urandom_range(0, 6) << 2) | $urandom_range(0, 3));
            rrw = 1'($urandom_range(0, 1));
            rd  = $urandom;
            xact(rrw, ra, rd);
        end

`ifdef SAP1_PIO_CYCLE_CNT_EN
        xact(1'b0, 16'h0004, 32'd0);
        xact(1'b0, 16'h001C, 32'd0);
        xact(1'b0, 16'h0004, 32'd1);
        repeat (7) @(posedge clk);
        #1;
        xact(1'b0, 16'h0004, 32'd0);
        m_cyc = 32'd10;
        xact(1'b1, 16'h001C, 32'd0);
`else
        xact(1'b1, 16'h001C, 32'd0);
        xact(1'b1, 16'h0018, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
